// File: rtl/alu_seq_if.sv
// alu_seq_if -- controller <-> ALU bundle for the multi-cycle datapath.
//
// Handshake: the controller raises start with aluOp/A/B for one cycle while
// busy is 0; the ALU samples them on that rising edge. The ALU answers with a
// one-cycle done pulse, and Result/Zero (and hi/lo for mul/div) are valid
// while done is high. A start seen while busy is 1 is dropped, not queued.
//
// Signals:
//   start, aluOp[3:0], A, B      controller -> ALU request
//   Result, Zero                 registered result and zero flag
//   busy                         multiply/divide in progress
//   done                         one-cycle completion pulse
//   hi, lo                       HI/LO registers
//   state_dbg[1:0]               current FSM state (0 IDLE, 1 RUN, 2 FIX)
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       aluOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       state_dbg;

    modport master (
        output start, aluOp, A, B,
        input  Result, Zero, busy, done, hi, lo, state_dbg
    );

    modport slave (
        input  start, aluOp, A, B,
        output Result, Zero, busy, done, hi, lo, state_dbg
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq -- sequential ALU with a registered output and an iterative
// multiply/divide engine that writes HI/LO.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_seq_if.slave (start/aluOp/A/B in; Result/Zero/busy/done/hi/lo
//          and state_dbg out)
//
// Single-cycle codes finish on the sampling edge. MULT/MULTU/DIV/DIVU go
// IDLE -> RUN (WIDTH iterations) -> FIX (sign correction), so done appears
// WIDTH+1 edges after the sampling edge.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic             zero_q, done_q;

    // Iteration registers shared by both engines:
    //   multiply: hw_q = running high half, lw_q = multiplier / low half
    //   divide:   hw_q = partial remainder, lw_q = dividend / quotient
    logic [WIDTH-1:0] hw_q, lw_q, m_q, a_orig_q;
    logic             is_div_q, div0_q, neg_q_q, neg_r_q;

    // ---------------- request decode ----------------
    logic             is_muldiv, op_signed;
    logic [WIDTH-1:0] a_mag, b_mag, alu_res;
    logic             slt, sltu;

    assign is_muldiv = bus.aluOp[3] & ~bus.aluOp[2];
    assign op_signed = ~bus.aluOp[0];
    // The magnitude of the most-negative value is itself when read unsigned.
    assign a_mag = (op_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign b_mag = (op_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    assign slt   = $signed(bus.A) < $signed(bus.B);
    assign sltu  = bus.A < bus.B;

    always_comb begin
        alu_res = '0;
        case (bus.aluOp)
            4'b0000: alu_res = bus.A + bus.B;
            4'b0001: alu_res = bus.A - bus.B;
            4'b0010: alu_res = {{(WIDTH-1){1'b0}}, slt};
            4'b0011: alu_res = {{(WIDTH-1){1'b0}}, sltu};
            4'b0100: alu_res = bus.A & bus.B;
            4'b0101: alu_res = bus.A | bus.B;
            4'b0110: alu_res = bus.A ^ bus.B;
            4'b0111: alu_res = ~(bus.A | bus.B);
            4'b1100: alu_res = hi_q;
            4'b1101: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // ---------------- iteration step ----------------
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    assign mul_sum  = {1'b0, hw_q} + (lw_q[0] ? {1'b0, m_q} : '0);
    assign div_sh   = {hw_q, lw_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, m_q};

    // ---------------- sign fix-up ----------------
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    always_comb begin
        prod   = {hw_q, lw_q};
        fix_hi = '0;
        fix_lo = '0;
        if (!is_div_q) begin
            if (neg_q_q) prod = -prod;
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else if (div0_q) begin
            fix_hi = a_orig_q;
            fix_lo = '1;
        end else begin
            // MIN / -1 needs no special path: quotient magnitude 2^(W-1)
            // negates to itself and the remainder is 0.
            fix_lo = neg_q_q ? -lw_q : lw_q;
            fix_hi = neg_r_q ? -hw_q : hw_q;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start && is_muldiv) state_d = RUN;
            RUN:     if (cnt_q == CW'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            hw_q     <= '0;
            lw_q     <= '0;
            m_q      <= '0;
            a_orig_q <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !is_muldiv) begin
                        result_q <= alu_res;
                        zero_q   <= (alu_res == '0);
                        done_q   <= 1'b1;
                    end else if (bus.start) begin
                        cnt_q    <= CW'(WIDTH);
                        is_div_q <= bus.aluOp[1];
                        div0_q   <= (bus.B == '0);
                        a_orig_q <= bus.A;
                        neg_q_q  <= op_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        neg_r_q  <= op_signed & bus.A[WIDTH-1];
                        hw_q     <= '0;
                        lw_q     <= bus.aluOp[1] ? a_mag : b_mag;
                        m_q      <= bus.aluOp[1] ? b_mag : a_mag;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (!is_div_q) begin
                        hw_q <= mul_sum[WIDTH:1];
                        lw_q <= {mul_sum[0], lw_q[WIDTH-1:1]};
                    end else if (!div_diff[WIDTH]) begin
                        hw_q <= div_diff[WIDTH-1:0];
                        lw_q <= {lw_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hw_q <= div_sh[WIDTH-1:0];
                        lw_q <= {lw_q[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    hi_q     <= fix_hi;
                    lo_q     <= fix_lo;
                    result_q <= fix_lo;
                    zero_q   <= (fix_lo == '0);
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Result    = result_q;
    assign bus.Zero      = zero_q;
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.state_dbg = state_q;
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU for the multi-cycle datapath. It keeps the existing arithmetic/logic operation set and registers its output, and adds an iterative multiply/divide engine with HI/LO registers. The datapath controller starts operations with a `start`/`done` handshake. The controller holds its state while `busy` is high, so long operations stall the datapath for a deterministic number of cycles.

## Interface
- `WIDTH`, default 32: operand, result, HI and LO width; must be ≥ 4.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `aluOp`  in  4  operation code, sampled with `start`.
- `A`  in  WIDTH  operand A (dividend or multiplicand), sampled with `start`.
- `B`  in  WIDTH  operand B (divisor or multiplier), sampled with `start`.
- `Result`  out  WIDTH  registered result.
- `Zero`  out  1  registered; 1 when `Result`==0.
- `busy`  out  1  multiply/divide in progress.
- `done`  out  1  one-cycle pulse; `Result`/`Zero` (and `hi`/`lo` for mul/div) valid.
- `hi`, `lo`  out  WIDTH each  HI/LO registers.

## Operation
- Reset, asynchronous:
  - `Result`=0, `Zero`=1, `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - FSM returns to IDLE.
- Operation codes when `aluOp[3]`=0, with `aluOp[2]` selecting the logic group:
  - 0000 ADD, 0001 SUB, wrap modulo 2^WIDTH, no overflow flag.
  - 0010 SLT (signed), 0011 SLTU; result is 0 or 1.
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR.
- Operation codes when `aluOp[3]`=1:
  - 1000 MULT, 1001 MULTU: {hi,lo} = full 2·WIDTH product.
  - 1010 DIV, 1011 DIVU: lo = quotient, hi = remainder.
  - 1100 MFHI (Result=hi), 1101 MFLO (Result=lo); both single-cycle.
  - 1110, 1111 reserved: Result=0, Zero=1, single-cycle.
- FSM state IDLE:
  - `start`=1 with a single-cycle code: register Result/Zero, pulse `done`, stay in IDLE.
  - `start`=1 with a mul/div code: latch operands as magnitudes (signed ops take the absolute value; record result signs), load the counter with WIDTH, go to RUN.
- FSM state RUN performs one iteration per cycle and decrements the counter; it goes to FIX after WIDTH iterations.
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring, one quotient bit per cycle.
- FSM state FIX applies the sign correction, writes hi/lo, sets `Result`=lo and `Zero`=(lo==0), pulses `done`, then returns to IDLE.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero (B=0, DIV or DIVU): lo = all ones, hi = A. The full latency still applies.
- Signed overflow (DIV, A = most-negative value, B = −1): lo = A, hi = 0.
- `hi`/`lo` are changed only by FIX and by reset. Single-cycle operations leave them unchanged.
- `start` while `busy`=1: ignored; operands are not re-sampled.

## Timing
- Edge E0 is the edge that samples `start`=1.
- Single-cycle operations: `Result`/`Zero` update at E0. `done`=1 for exactly the cycle after E0; latency is 1.
- Mul/div:
  - `busy` rises at E0.
  - RUN iterations occur on edges E1..E(WIDTH).
  - FIX completes at E(WIDTH+1): `busy` falls, `done`=1 for one cycle, and `hi`/`lo`/`Result`/`Zero` take new values. Latency is WIDTH+1 edges.
- Back-to-back: a new `start` is accepted on the edge right after the `done` pulse begins (`busy` is already 0).
- `Result` holds its value between operations.
- Reset asserted mid-RUN aborts immediately to reset values. The first `start` after deassertion is accepted normally.

## Test plan
- ADD A=5, B=−5 → Result=0, Zero=1, done one cycle after E0. NOR A=0, B=0 → Result=all ones, Zero=0.
- MULT, WIDTH=32, A=−3, B=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1 at E33; `busy` high for exactly 33 cycles; then MFHI → Result=0xFFFFFFFF.
- DIVU 100/7 → lo=14, hi=2. DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- DIV A=9, B=0 → lo=0xFFFFFFFF, hi=9, done at E33.
- Pulse `start` with ADD at E10 during a MULT → ignored; MULT result and timing unchanged; no extra `done`.
- Assert `rst_n`=0 mid-DIVU → all outputs at reset values immediately; after release, MULTU 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE.
